mem_port_arbiter: RTL and testbench

- Shares the single-port, word-addressed data memory between two requesters: port 0 (load unit) and port 1 (store unit / second LSU).
- Grants are round-robin, one memory access per cycle.
- Read data is returned one cycle after the grant (synchronous memory) and routed back to the owning port with a valid strobe.
- Sits between the execute-stage memory units and the data memory macro. It replaces the direct mem_addr / mem_rw_mode drive from each unit.

---
 rtl/mem_port_arbiter.sv | 102 ++++++++++
 tb/tb_mem_port_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous data memory between
// the load unit (port 0) and the store unit (port 1); read data returns one cycle after grant.
module mem_port_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic                i_clk,
    input  logic                i_rst,

    input  logic                req0,
    input  logic                we0,
    input  logic [ADDR_W-1:0]   addr0,
    input  logic [DATA_W-1:0]   wdata0,
    input  logic [DATA_W/8-1:0] wstrb0,
    output logic                gnt0,
    output logic                rvalid0,
    output logic [DATA_W-1:0]   rdata0,

    input  logic                req1,
    input  logic                we1,
    input  logic [ADDR_W-1:0]   addr1,
    input  logic [DATA_W-1:0]   wdata1,
    input  logic [DATA_W/8-1:0] wstrb1,
    output logic                gnt1,
    output logic                rvalid1,
    output logic [DATA_W-1:0]   rdata1,

    output logic                mem_rw_mode,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic                mem_en,
    input  logic [DATA_W-1:0]   mem_rdata
);

    // prio names the port that wins the next contended cycle
    logic prio;
    logic rd_pend;
    logic rd_owner;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!i_rst) begin
            if (req0 && (!req1 || !prio)) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
    end

    // Winner's request is steered straight to the memory macro in the grant cycle
    always_comb begin
        mem_en      = 1'b0;
        mem_rw_mode = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_wstrb   = '0;
        if (gnt0) begin
            mem_en      = 1'b1;
            mem_rw_mode = we0;
            mem_addr    = addr0;
            mem_wdata   = wdata0;
            mem_wstrb   = we0 ? wstrb0 : '0;
        end else if (gnt1) begin
            mem_en      = 1'b1;
            mem_rw_mode = we1;
            mem_addr    = addr1;
            mem_wdata   = wdata1;
            mem_wstrb   = we1 ? wstrb1 : '0;
        end
    end

    // ---- grant stage -> read-return stage ----
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            prio     <= 1'b0;
            rd_pend  <= 1'b0;
            rd_owner <= 1'b0;
        end else begin
            if (gnt0) begin
                prio <= 1'b1;
            end else if (gnt1) begin
                prio <= 1'b0;
            end
            rd_pend <= mem_en && !mem_rw_mode;
            if (mem_en && !mem_rw_mode) begin
                rd_owner <= gnt1;
            end
        end
    end

    // A read in flight when reset arrives never surfaces
    always_comb begin
        rvalid0 = rd_pend && !rd_owner && !i_rst;
        rvalid1 = rd_pend &&  rd_owner && !i_rst;
        rdata0  = rvalid0 ? mem_rdata : '0;
        rdata1  = rvalid1 ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: behavioural memory, per-cycle grant checks,
// and a read-return scoreboard keyed by the cycle each read data word is due.
module tb_mem_port_arbiter;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic              req0, we0, gnt0, rvalid0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0, rdata0;
    logic [STRB_W-1:0] wstrb0;
    logic              req1, we1, gnt1, rvalid1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1, rdata1;
    logic [STRB_W-1:0] wstrb1;
    logic              mem_rw_mode, mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic [STRB_W-1:0] mem_wstrb;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .wstrb0(wstrb0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .wstrb1(wstrb1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_rw_mode(mem_rw_mode), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_en(mem_en), .mem_rdata(mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int          port;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          fails  = 0;
    int          cyc    = 0;
    logic [31:0] model_mem[1024];
    logic [31:0] shadow[1024];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Synchronous memory: writes land at the edge, read data appears the next cycle
    always @(posedge i_clk) begin
        cyc <= cyc + 1;
        if (mem_en && mem_rw_mode) begin
            for (int b = 0; b < STRB_W; b++)
                if (mem_wstrb[b]) model_mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        if (mem_en && !mem_rw_mode) mem_rdata <= model_mem[mem_addr];
        else                        mem_rdata <= 32'hBAD0BAD0;
    end

    // Read-return monitor
    always @(negedge i_clk) begin
        exp_t e;
        if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            chk("rvalid0", 32'(rvalid0), 32'(e.port == 0));
            chk("rvalid1", 32'(rvalid1), 32'(e.port == 1));
            if (e.port == 0) chk("rdata0", rdata0, e.data);
            else             chk("rdata1", rdata1, e.data);
        end else begin
            chk("rvalid0_idle", 32'(rvalid0), 32'd0);
            chk("rvalid1_idle", 32'(rvalid1), 32'd0);
            chk("rdata0_idle", rdata0, 32'd0);
            chk("rdata1_idle", rdata1, 32'd0);
        end
        chk("gnt_onehot", 32'(gnt0 & gnt1), 32'd0);
    end

    task automatic drive(input logic rst,
                         input logic r0, input logic w0, input logic [ADDR_W-1:0] a0,
                         input logic [DATA_W-1:0] d0, input logic [STRB_W-1:0] s0,
                         input logic r1, input logic w1, input logic [ADDR_W-1:0] a1,
                         input logic [DATA_W-1:0] d1, input logic [STRB_W-1:0] s1);
        @(posedge i_clk);
        #1;
        i_rst = rst;
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0; wstrb0 = s0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1; wstrb1 = s1;
    endtask

    // win: -1 no grant, 0 or 1 expected winner; push schedules the read return
    task automatic check_cycle(input int win, input bit push);
        logic              e_we;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_wdata;
        logic [STRB_W-1:0] e_wstrb;
        @(negedge i_clk);
        e_we = 1'b0; e_addr = '0; e_wdata = '0; e_wstrb = '0;
        if (win == 0) begin
            e_we = we0; e_addr = addr0; e_wdata = wdata0; e_wstrb = we0 ? wstrb0 : '0;
        end else if (win == 1) begin
            e_we = we1; e_addr = addr1; e_wdata = wdata1; e_wstrb = we1 ? wstrb1 : '0;
        end
        chk("gnt0", 32'(gnt0), 32'(win == 0));
        chk("gnt1", 32'(gnt1), 32'(win == 1));
        chk("mem_en", 32'(mem_en), 32'(win >= 0));
        chk("mem_rw_mode", 32'(mem_rw_mode), 32'(e_we));
        chk("mem_addr", 32'(mem_addr), 32'(e_addr));
        chk("mem_wdata", mem_wdata, e_wdata);
        chk("mem_wstrb", 32'(mem_wstrb), 32'(e_wstrb));
        if (win >= 0 && e_we) begin
            for (int b = 0; b < STRB_W; b++)
                if (e_wstrb[b]) shadow[e_addr][8*b +: 8] = e_wdata[8*b +: 8];
        end else if (win >= 0 && push) begin
            q.push_back('{win, shadow[e_addr], cyc + 1});
        end
    endtask

    initial begin
        i_rst = 1'b1;
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0; wstrb0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0; wstrb1 = '0;
        for (int i = 0; i < 1024; i++) begin
            model_mem[i] = 32'hC0DE0000 | 32'(i);
            shadow[i]    = 32'hC0DE0000 | 32'(i);
        end
        model_mem[10'h03A] = 32'hDEADBEEF;
        shadow[10'h03A]    = 32'hDEADBEEF;

        // Reset with both ports requesting
        repeat (2) begin
            drive(1, 1, 0, 10'h03A, 32'h11111111, 4'hF, 1, 1, 10'h010, 32'h22222222, 4'hF);
            check_cycle(-1, 0);
        end
        // First cycle after reset: port 0 favoured
        drive(0, 1, 0, 10'h03A, 32'h0, 4'h0, 1, 0, 10'h010, 32'h0, 4'h0);
        check_cycle(0, 1);

        // Single read by port 0
        drive(0, 1, 0, 10'h03A, 32'h0, 4'h0, 0, 0, 10'h0, 32'h0, 4'h0);
        check_cycle(0, 1);
        drive(0, 0, 0, 10'h0, 32'h0, 4'h0, 0, 0, 10'h0, 32'h0, 4'h0);
        check_cycle(-1, 0);

        // Write pass-through on port 1, then an idle cycle with no rvalid1
        drive(0, 0, 0, 10'h0, 32'h0, 4'h0, 1, 1, 10'h010, 32'h12345678, 4'b0011);
        check_cycle(1, 0);
        drive(0, 0, 0, 10'h0, 32'h0, 4'h0, 0, 0, 10'h0, 32'h0, 4'h0);
        check_cycle(-1, 0);

        // Contention: grants alternate 0,1,0,1
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, 10'(32'h20 + i), 32'(i), 4'h0, 1, 0, 10'(32'h40 + i), 32'(i + 8), 4'h0);
            check_cycle(i % 2, 1);
        end

        // Back-to-back: port 0 read, then port 1 write to the same word while the read returns
        drive(0, 1, 0, 10'h005, 32'h0, 4'h0, 0, 0, 10'h0, 32'h0, 4'h0);
        check_cycle(0, 1);
        drive(0, 0, 0, 10'h0, 32'h0, 4'h0, 1, 1, 10'h005, 32'hCAFEF00D, 4'hF);
        check_cycle(1, 0);
        chk("b2b_overlap", 32'({rvalid0, gnt1, mem_rw_mode}), 32'b111);
        // Read-after-write returns the new data
        drive(0, 1, 0, 10'h005, 32'h0, 4'h0, 0, 0, 10'h0, 32'h0, 4'h0);
        check_cycle(0, 1);
        drive(0, 0, 0, 10'h0, 32'h0, 4'h0, 0, 0, 10'h0, 32'h0, 4'h0);
        check_cycle(-1, 0);

        // Reset with a port-1 read in flight: the return is dropped
        drive(0, 0, 0, 10'h0, 32'h0, 4'h0, 1, 0, 10'h010, 32'h0, 4'h0);
        check_cycle(1, 0);
        drive(1, 0, 0, 10'h0, 32'h0, 4'h0, 0, 0, 10'h0, 32'h0, 4'h0);
        check_cycle(-1, 0);
        // prio back at 0 after reset
        drive(0, 1, 0, 10'h03A, 32'h0, 4'h0, 1, 0, 10'h010, 32'h0, 4'h0);
        check_cycle(0, 1);
        repeat (2) begin
            drive(0, 0, 0, 10'h0, 32'h0, 4'h0, 0, 0, 10'h0, 32'h0, 4'h0);
            check_cycle(-1, 0);
        end
        chk("queue_empty", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
